// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with prescaled tick, pause/resume and a done pulse.
// Input priority on each edge is reset > load > start > pause > tick.
module bcd_countdown_timer #(
  parameter int unsigned W = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t      state, state_n;
  logic [3:0]  tens_n, ones_n;
  logic [3:0]  rel_tens, rel_ones, rel_tens_n, rel_ones_n;
  logic [31:0] presc, presc_n;
  logic        done_n;
  logic        tick;
  logic [3:0]  ld_tens, ld_ones;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign ld_tens = clamp9(load_val[7:4]);
  assign ld_ones = clamp9(load_val[3:0]);
  assign tick    = (presc == W);

  assign busy    = (state == RUN) || (state == PAUSED);
  assign expired = (state == DONE);

  always_comb begin
    state_n    = state;
    tens_n     = tens;
    ones_n     = ones;
    rel_tens_n = rel_tens;
    rel_ones_n = rel_ones;
    presc_n    = presc;
    done_n     = 1'b0;

    if (load) begin
      tens_n     = ld_tens;
      ones_n     = ld_ones;
      rel_tens_n = ld_tens;
      rel_ones_n = ld_ones;
      presc_n    = '0;
      state_n    = IDLE;
    end else if (start && (state == IDLE || state == DONE)) begin
      tens_n  = rel_tens;
      ones_n  = rel_ones;
      presc_n = '0;
      if (rel_tens == 4'd0 && rel_ones == 4'd0) begin
        state_n = DONE;
        done_n  = 1'b1;
      end else begin
        state_n = RUN;
      end
    end else if (start && state == PAUSED) begin
      // Resume keeps the held prescaler so the interrupted period is not restarted.
      state_n = RUN;
    end else begin
      case (state)
        RUN: begin
          if (pause && !start) begin
            state_n = PAUSED;
          end else if (tick) begin
            presc_n = '0;
            if (tens == 4'd0 && ones <= 4'd1) begin
              tens_n  = 4'd0;
              ones_n  = 4'd0;
              state_n = DONE;
              done_n  = 1'b1;
            end else if (ones != 4'd0) begin
              ones_n = ones - 4'd1;
            end else begin
              ones_n = 4'd9;
              tens_n = tens - 4'd1;
            end
          end else begin
            presc_n = presc + 32'd1;
          end
        end
        PAUSED:  presc_n = presc;
        default: presc_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tens     <= 4'd0;
      ones     <= 4'd0;
      rel_tens <= 4'd0;
      rel_ones <= 4'd0;
      presc    <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      tens     <= tens_n;
      ones     <= ones_n;
      rel_tens <= rel_tens_n;
      rel_ones <= rel_ones_n;
      presc    <= presc_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (W=1): each step pairs the inputs for one edge
// with the outputs expected after it; every scenario task drains the queue and compares.
module tb_bcd_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       expired;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       ps;
    logic [3:0] t;
    logic [3:0] o;
    logic       b;
    logic       e;
    logic       d;
  } step_t;

  step_t q[$];

  bcd_countdown_timer #(.W(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .tens     (tens),
    .ones     (ones),
    .busy     (busy),
    .expired  (expired),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void push_step(input logic rst, input logic ld, input logic [7:0] lv,
                                    input logic st, input logic ps, input logic [3:0] t,
                                    input logic [3:0] o, input logic b, input logic e,
                                    input logic d);
    step_t s;
    s.rst = rst; s.ld = ld; s.lv = lv; s.st = st; s.ps = ps;
    s.t = t; s.o = o; s.b = b; s.e = e; s.d = d;
    q.push_back(s);
  endfunction

  task automatic test_reset();
    int idx = 0;
    push_step(1, 0, 8'h00, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    push_step(1, 1, 8'h99, 1, 0, 4'd0, 4'd0, 0, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      reset = s.rst; load = s.ld; load_val = s.lv; start = s.st; pause = s.ps;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({tens, ones, busy, expired, done} !== {s.t, s.o, s.b, s.e, s.d}) begin
        errors++;
        $display("[TB] FAIL reset step %0d: got %0d%0d b%0b e%0b d%0b, want %0d%0d b%0b e%0b d%0b",
                 idx, tens, ones, busy, expired, done, s.t, s.o, s.b, s.e, s.d);
      end
      idx++;
    end
  endtask

  task automatic test_countdown();
    int idx = 0;
    int n = 12;
    push_step(0, 1, 8'h12, 0, 0, 4'd1, 4'd2, 0, 0, 0);
    push_step(0, 0, 8'h00, 1, 0, 4'd1, 4'd2, 1, 0, 0);
    for (int k = 1; k <= 24; k++) begin
      if (k % 2 == 0) n--;
      push_step(0, 0, 8'h00, 0, 0, 4'(n / 10), 4'(n % 10), (n != 0), (n == 0), (k == 24));
    end
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      reset = s.rst; load = s.ld; load_val = s.lv; start = s.st; pause = s.ps;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({tens, ones, busy, expired, done} !== {s.t, s.o, s.b, s.e, s.d}) begin
        errors++;
        $display("[TB] FAIL countdown step %0d: got %0d%0d b%0b e%0b d%0b, want %0d%0d b%0b e%0b d%0b",
                 idx, tens, ones, busy, expired, done, s.t, s.o, s.b, s.e, s.d);
      end
      idx++;
    end
  endtask

  task automatic test_borrow();
    int idx = 0;
    push_step(0, 1, 8'h10, 0, 0, 4'd1, 4'd0, 0, 0, 0);
    push_step(0, 0, 8'h00, 1, 0, 4'd1, 4'd0, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd1, 4'd0, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd9, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd9, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd8, 1, 0, 0);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      reset = s.rst; load = s.ld; load_val = s.lv; start = s.st; pause = s.ps;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({tens, ones, busy, expired, done} !== {s.t, s.o, s.b, s.e, s.d}) begin
        errors++;
        $display("[TB] FAIL borrow step %0d: got %0d%0d b%0b e%0b d%0b, want %0d%0d b%0b e%0b d%0b",
                 idx, tens, ones, busy, expired, done, s.t, s.o, s.b, s.e, s.d);
      end
      idx++;
    end
  endtask

  task automatic test_pause();
    int idx = 0;
    push_step(0, 1, 8'h05, 0, 0, 4'd0, 4'd5, 0, 0, 0);
    push_step(0, 0, 8'h00, 1, 0, 4'd0, 4'd5, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd5, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd4, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd4, 1, 0, 0);
    // pause lands on an edge where a tick is due; prescaler is left at 1
    for (int k = 0; k < 6; k++) push_step(0, 0, 8'h00, 0, 1, 4'd0, 4'd4, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd4, 1, 0, 0);
    push_step(0, 0, 8'h00, 1, 0, 4'd0, 4'd4, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd3, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd3, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd2, 1, 0, 0);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      reset = s.rst; load = s.ld; load_val = s.lv; start = s.st; pause = s.ps;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({tens, ones, busy, expired, done} !== {s.t, s.o, s.b, s.e, s.d}) begin
        errors++;
        $display("[TB] FAIL pause step %0d: got %0d%0d b%0b e%0b d%0b, want %0d%0d b%0b e%0b d%0b",
                 idx, tens, ones, busy, expired, done, s.t, s.o, s.b, s.e, s.d);
      end
      idx++;
    end
  endtask

  task automatic test_clamp_zero();
    int idx = 0;
    push_step(0, 1, 8'hAF, 0, 0, 4'd9, 4'd9, 0, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd9, 4'd9, 0, 0, 0);
    push_step(0, 1, 8'h3C, 0, 0, 4'd3, 4'd9, 0, 0, 0);
    push_step(0, 1, 8'hB4, 0, 0, 4'd9, 4'd4, 0, 0, 0);
    push_step(0, 1, 8'h00, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    push_step(0, 0, 8'h00, 1, 0, 4'd0, 4'd0, 0, 1, 1);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      reset = s.rst; load = s.ld; load_val = s.lv; start = s.st; pause = s.ps;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({tens, ones, busy, expired, done} !== {s.t, s.o, s.b, s.e, s.d}) begin
        errors++;
        $display("[TB] FAIL clamp_zero step %0d: got %0d%0d b%0b e%0b d%0b, want %0d%0d b%0b e%0b d%0b",
                 idx, tens, ones, busy, expired, done, s.t, s.o, s.b, s.e, s.d);
      end
      idx++;
    end
  endtask

  task automatic test_reset_abort();
    int idx = 0;
    push_step(0, 1, 8'h03, 0, 0, 4'd0, 4'd3, 0, 0, 0);
    push_step(0, 0, 8'h00, 1, 0, 4'd0, 4'd3, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd3, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd2, 1, 0, 0);
    push_step(1, 1, 8'h55, 1, 0, 4'd0, 4'd0, 0, 0, 0);
    push_step(0, 0, 8'h00, 1, 0, 4'd0, 4'd0, 0, 1, 1);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      reset = s.rst; load = s.ld; load_val = s.lv; start = s.st; pause = s.ps;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({tens, ones, busy, expired, done} !== {s.t, s.o, s.b, s.e, s.d}) begin
        errors++;
        $display("[TB] FAIL reset_abort step %0d: got %0d%0d b%0b e%0b d%0b, want %0d%0d b%0b e%0b d%0b",
                 idx, tens, ones, busy, expired, done, s.t, s.o, s.b, s.e, s.d);
      end
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    push_step(0, 1, 8'h02, 0, 0, 4'd0, 4'd2, 0, 0, 0);
    push_step(0, 0, 8'h00, 1, 0, 4'd0, 4'd2, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd2, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd1, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd1, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd0, 0, 1, 1);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd0, 0, 1, 0);
    push_step(0, 0, 8'h00, 1, 0, 4'd0, 4'd2, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd2, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd1, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd1, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd0, 4'd0, 0, 1, 1);
    push_step(0, 1, 8'h47, 1, 0, 4'd4, 4'd7, 0, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd4, 4'd7, 0, 0, 0);
    push_step(0, 0, 8'h00, 1, 0, 4'd4, 4'd7, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd4, 4'd7, 1, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd4, 4'd6, 1, 0, 0);
    push_step(0, 1, 8'h21, 0, 0, 4'd2, 4'd1, 0, 0, 0);
    push_step(0, 0, 8'h00, 0, 0, 4'd2, 4'd1, 0, 0, 0);
    while (q.size() > 0) begin
      step_t s = q.pop_front();
      reset = s.rst; load = s.ld; load_val = s.lv; start = s.st; pause = s.ps;
      @(posedge clk); @(negedge clk);
      checks++;
      if ({tens, ones, busy, expired, done} !== {s.t, s.o, s.b, s.e, s.d}) begin
        errors++;
        $display("[TB] FAIL back_to_back step %0d: got %0d%0d b%0b e%0b d%0b, want %0d%0d b%0b e%0b d%0b",
                 idx, tens, ones, busy, expired, done, s.t, s.o, s.b, s.e, s.d);
      end
      idx++;
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;
    @(negedge clk);
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_clamp_zero();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter: W, default 1 (synthesis 50_000_000), prescaler terminal count; one tick every W+1 clk cycles.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; one clock, synchronous active-high reset, no other clock or async path.
REQ-004 load  input  1  capture load_val as new start value.
REQ-005 load_val  input  8  two BCD digits, [7:4] tens, [3:0] ones.
REQ-006 start  input  1  begin/resume/restart countdown.
REQ-007 pause  input  1  level; holds countdown while high in RUN.
REQ-008 tens  output  4  current tens digit, registered.
REQ-009 ones  output  4  current ones digit, registered.
REQ-010 busy  output  1  high in RUN and PAUSED.
REQ-011 expired  output  1  level, high in DONE.
REQ-012 done  output  1  one-cycle pulse on entry to DONE.

Function
REQ-013 States: IDLE, RUN, PAUSED, DONE; busy/expired decoded from registered state.
REQ-014 Prescaler: 32-bit count 0..W; tick = (count==W) while in RUN; count wraps to 0 on tick; held (not cleared) in PAUSED; cleared in IDLE/DONE and on start from IDLE/DONE.
REQ-015 Input priority per edge: reset > load > start > pause > tick.
REQ-016 load in any state: digits and reload register <= load_val, state -> IDLE, prescaler cleared, done low.
REQ-017 Digit field >9 on load clamps to 9 (tens and ones independently).
REQ-018 start in IDLE or DONE: digits <= reload register; if reload==00 -> DONE with done pulse next cycle; else -> RUN, prescaler 0.
REQ-019 start in PAUSED -> RUN, prescaler resumes from held value; start in RUN ignored.
REQ-020 pause high in RUN (and no load/start) -> PAUSED at that edge, no decrement even if tick coincides.
REQ-021 Tick in RUN: ones!=0 -> ones-1; ones==0 -> ones=9, tens-1.
REQ-022 Decrement yielding 00 -> state DONE same edge; done=1 for exactly that following cycle.
REQ-023 Latency: start sampled at edge N, first decrement at edge N+W+1, then every W+1 edges.
REQ-024 DONE holds 00, expired=1 until load, start, or reset.
REQ-025 Digits never leave 0..9; no underflow past 00.

Reset
REQ-026 reset: state IDLE, tens=0, ones=0, reload register 00, prescaler 0, busy=0, expired=0, done=0.
REQ-027 reset mid-RUN/PAUSED aborts immediately; outputs per REQ-026 next cycle; load/start in reset cycle ignored.

Verification (W=1)
REQ-028 load 0x12, start -> 12,11,10,09..00 each 2 cycles; done one cycle at 00; expired held; busy low after.
REQ-029 load 0x10, start -> after 2 cycles tens=0 ones=9 (borrow).
REQ-030 load 0x05, start, pause high 6 cycles mid-run -> digits frozen, busy=1; start -> resume, prescaler not reset.
REQ-031 load 0xAF -> tens=9 ones=9; load 0x00, start -> DONE, done pulse, no RUN cycle.
REQ-032 load 0x03, start, reset after 3 cycles -> all outputs 0, state IDLE; subsequent start -> immediate DONE (reload 00).
REQ-033 in DONE after 0x02 run, start -> reloads 02, counts 02,01,00 again; load+start same edge -> IDLE with loaded value.
